// File: rtl/edge_pkg.sv
// Shared constants and stage bundles for the YCrCb colour-space blocks.
// Coefficients are 8-bit fixed point (x256).
package edge_pkg;

  localparam int SW     = 18;
  localparam int C_RV   = 359;
  localparam int C_GU   = 88;
  localparam int C_GV   = 183;
  localparam int C_BU   = 454;
  localparam int OFFSET = 128;
  localparam int RND    = 128;

  typedef logic signed [SW-1:0] sum_t;

  typedef struct packed {
    sum_t y;
    sum_t pr;
    sum_t pgb;
    sum_t pgr;
    sum_t pb;
  } s1_t;

  typedef struct packed {
    sum_t r;
    sum_t g;
    sum_t b;
  } s2_t;

  function automatic logic signed [8:0] unbias(input logic [7:0] c);
    return signed'({1'b0, c}) - signed'(9'(OFFSET));
  endfunction

endpackage

// File: rtl/clamp8.sv
// Saturates a signed sum to the unsigned 0..255 range.
module clamp8
  import edge_pkg::*;
(
  input  logic signed [SW-1:0] d,
  output logic        [7:0]    q
);

  localparam logic signed [SW-1:0] MAXV = SW'(255);

  always_comb begin
    q = d[7:0];
    if (d < 0)
      q = 8'd0;
    else if (d > MAXV)
      q = 8'd255;
  end

endmodule

// File: rtl/ycrcb2rgb565.sv
// Three-stage YCrCb to RGB565 converter with valid/ready flow control.
// All stages advance together; the last stage stalls the whole pipe.
module ycrcb2rgb565
  import edge_pkg::*;
#(
  parameter int ROUND = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] Y,
  input  logic [7:0] Cr,
  input  logic [7:0] Cb,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] R,
  output logic [5:0] G,
  output logic [4:0] B
);

  localparam sum_t RC = sum_t'((ROUND != 0) ? RND : 0);

  logic v1, v2, v3;
  logic en;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic [7:0] r8, g8, b8;

  assign en        = ~v3 | out_ready;
  assign in_ready  = en;
  assign out_valid = v3;

  always_comb begin
    logic signed [8:0] dr;
    logic signed [8:0] db;
    dr       = unbias(Cr);
    db       = unbias(Cb);
    s1_d     = '0;
    s1_d.y   = {2'b00, Y, 8'h00};
    s1_d.pr  = sum_t'(dr) * sum_t'(C_RV);
    s1_d.pgb = sum_t'(db) * sum_t'(C_GU);
    s1_d.pgr = sum_t'(dr) * sum_t'(C_GV);
    s1_d.pb  = sum_t'(db) * sum_t'(C_BU);
  end

  always_comb begin
    sum_t rs, gs, bs;
    rs     = s1_q.y + s1_q.pr + RC;
    gs     = s1_q.y - s1_q.pgb - s1_q.pgr + RC;
    bs     = s1_q.y + s1_q.pb + RC;
    s2_d   = '0;
    s2_d.r = rs >>> 8;
    s2_d.g = gs >>> 8;
    s2_d.b = bs >>> 8;
  end

  clamp8 u_clamp_r (.d(s2_q.r), .q(r8));
  clamp8 u_clamp_g (.d(s2_q.g), .q(g8));
  clamp8 u_clamp_b (.d(s2_q.b), .q(b8));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      R    <= '0;
      G    <= '0;
      B    <= '0;
    end else if (en) begin
      v1   <= in_valid;
      v2   <= v1;
      v3   <= v2;
      s1_q <= s1_d;
      s2_q <= s2_d;
      R    <= r8[7:3];
      G    <= g8[7:2];
      B    <= b8[7:3];
    end
  end

endmodule

// File: tb/tb_ycrcb2rgb565.sv
// Directed and swept checks for ycrcb2rgb565 (ROUND=1).
// Expected pixels come from hand values and an independent integer model.
module tb_ycrcb2rgb565;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic       out_valid, out_ready;
  logic [7:0] y, cr, cb;
  logic [4:0] r, b;
  logic [5:0] g;

  int vecs = 0;
  int errs = 0;
  logic acc, xfer;
  logic [15:0] q[$];
  logic [15:0] hold;
  int nacc, nxfer, k, guard, seen;

  int py[5]  = '{128, 255, 0, 200, 60};
  int pcr[5] = '{128, 255, 0, 100, 180};
  int pcb[5] = '{128, 128, 0, 50, 220};

  ycrcb2rgb565 #(.ROUND(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .Y(y), .Cr(cr), .Cb(cb),
    .out_valid(out_valid), .out_ready(out_ready),
    .R(r), .G(g), .B(b)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref565(input int yy, input int c_r, input int c_b);
    int dr, db, t;
    int s[3];
    logic [7:0] c[3];
    dr = c_r - 128;
    db = c_b - 128;
    s[0] = 256*yy + 359*dr;
    s[1] = 256*yy - 88*db - 183*dr;
    s[2] = 256*yy + 454*db;
    for (int i = 0; i < 3; i++) begin
      t = (s[i] + 128) >>> 8;
      if (t < 0) t = 0;
      if (t > 255) t = 255;
      c[i] = t[7:0];
    end
    return {c[0][7:3], c[1][7:2], c[2][7:3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int yy, input int c_r, input int c_b, input logic ordy);
    in_valid  = v;
    y         = yy[7:0];
    cr        = c_r[7:0];
    cb        = c_b[7:0];
    out_ready = ordy;
    #1;
    acc  = in_valid & in_ready;
    xfer = out_valid & out_ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic take(input string tag);
    nxfer++;
    if (q.size() == 0)
      chk({tag, "_extra"}, 32'd1, 32'd0);
    else
      chk(tag, {16'd0, r, g, b}, {16'd0, q.pop_front()});
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    y = '0; cr = '0; cb = '0;
    #12;
    chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
    chk("rst_rgb", {16'd0, r, g, b}, 32'd0);
    chk("rst_iready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // grey, bright red, black with known hand-derived results
    drive(1, 128, 128, 128, 1);
    chk("first_accept", {31'd0, acc}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 1);
    chk("lat_c1", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_c2", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_c3", {31'd0, out_valid}, 32'd1);
    chk("grey", {16'd0, r, g, b}, {16'd0, 5'd16, 6'd32, 5'd16});

    drive(1, 255, 255, 128, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    chk("red_c1", {31'd0, out_valid}, 32'd0);
    tick();
    tick();
    chk("red_ov", {31'd0, out_valid}, 32'd1);
    chk("red", {16'd0, r, g, b}, {16'd0, 5'd31, 6'd41, 5'd31});

    drive(1, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    tick();
    tick();
    chk("zero_ov", {31'd0, out_valid}, 32'd1);
    chk("zero", {16'd0, r, g, b}, {16'd0, 5'd0, 6'd34, 5'd0});
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1);
      tick();
    end

    // backpressure: offer five pixels with the sink stalled
    q.delete();
    k = 0;
    nacc = 0;
    for (int c = 0; c < 6; c++) begin
      if (k < 5) drive(1, py[k], pcr[k], pcb[k], 0);
      else drive(0, 0, 0, 0, 0);
      if (acc) begin
        q.push_back(ref565(py[k], pcr[k], pcb[k]));
        k++;
        nacc++;
      end
      tick();
    end
    chk("bp_accepted", nacc, 32'd3);
    drive(1, py[k], pcr[k], pcb[k], 0);
    chk("bp_iready", {31'd0, in_ready}, 32'd0);
    chk("bp_ovalid", {31'd0, out_valid}, 32'd1);
    hold = {r, g, b};
    tick();
    tick();
    chk("bp_stable", {16'd0, r, g, b}, {16'd0, hold});
    chk("bp_stable_ov", {31'd0, out_valid}, 32'd1);
    nxfer = 0;
    for (int c = 0; c < 20; c++) begin
      if (k < 5) drive(1, py[k], pcr[k], pcb[k], 1);
      else drive(0, 0, 0, 0, 1);
      if (xfer) take("bp_order");
      if (acc) begin
        q.push_back(ref565(py[k], pcr[k], pcb[k]));
        k++;
      end
      tick();
    end
    chk("bp_delivered", nxfer, 32'd5);

    // reset with three pixels in flight
    for (int c = 0; c < 4; c++) begin
      drive(1, 255, 255, 128, 0);
      tick();
    end
    chk("mr_full", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_ovalid", {31'd0, out_valid}, 32'd0);
    chk("mr_rgb", {16'd0, r, g, b}, 32'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 0, 0, 1);
      if (out_valid) seen++;
      tick();
    end
    chk("mr_no_stale", seen, 32'd0);

    // sweep in steps of 17 with random stalls and bubbles
    q.delete();
    nacc = 0;
    nxfer = 0;
    for (int iy = 0; iy < 16; iy++)
      for (int ir = 0; ir < 16; ir++)
        for (int ib = 0; ib < 16; ib++) begin
          guard = 0;
          do begin
            drive(($urandom % 4) != 0, iy*17, ir*17, ib*17, ($urandom % 4) != 0);
            if (xfer) take("sweep");
            if (acc) begin
              q.push_back(ref565(iy*17, ir*17, ib*17));
              nacc++;
            end
            tick();
            guard++;
          end while (!acc && guard < 60);
          if (!acc) chk("sweep_timeout", 32'd0, 32'd1);
        end
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 0, 0, 1);
      if (xfer) take("sweep");
      tick();
    end
    chk("sweep_count", nxfer, nacc);
    chk("sweep_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ycrcb2rgb565.md
YCRCB2RGB565 -- requirements
Module: ycrcb2rgb565

Interface
REQ-001 Parameter ROUND, default 1: 1 adds 128 before the final >>8 of each channel sum; 0 truncates.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset; active-high, asynchronous assert.
REQ-005 in_valid  input  1  Y/Cr/Cb carry a pixel.
REQ-006 in_ready  output  1  block accepts a pixel this cycle.
REQ-007 Y  input  8  luma, full range 0..255.
REQ-008 Cr  input  8  red chroma, offset 128.
REQ-009 Cb  input  8  blue chroma, offset 128.
REQ-010 out_valid  output  1  R/G/B carry a converted pixel.
REQ-011 out_ready  input  1  downstream accepts a pixel this cycle.
REQ-012 R  output  5  RGB565 red.
REQ-013 G  output  6  RGB565 green.
REQ-014 B  output  5  RGB565 blue.

Function
REQ-015 A transfer occurs on a rising edge with valid and ready both high, on either side.
REQ-016 Arithmetic uses signed operands: dr = Cr-128 and db = Cb-128, each 9-bit signed.
REQ-017 Sums use at least 18-bit signed width:
- Rs = 256*Y + 359*dr
- Gs = 256*Y - 88*db - 183*dr
- Bs = 256*Y + 454*db
REQ-018 Each sum has rounding applied per ROUND and is then arithmetic-shifted right by 8.
REQ-019 Each shifted result is clamped to 0..255 (negative gives 0, above 255 gives 255).
REQ-020 Packing: R = R8[7:3], G = G8[7:2], B = B8[7:3].
REQ-021 Pipeline has 3 registered stages, each with its own valid bit v1..v3:
- S1 registers dr, db and the products.
- S2 registers the rounded, shifted sums.
- S3 registers the clamped, packed outputs.
REQ-022 Advance enable: en = ~v3 | out_ready; in_ready = en, driven combinationally.
REQ-023 When en is high, all stages shift one place and v1 loads in_valid.
REQ-024 When en is low, all stage registers and valid bits hold.
REQ-025 Latency is 3 cycles from acceptance to out_valid when out_ready is held high.
REQ-026 Throughput is 1 pixel per cycle when out_ready is held high.
REQ-027 While out_valid is high and out_ready is low, R/G/B/out_valid stay stable until the transfer completes.
REQ-028 At most 3 pixels are in flight; no pixel is dropped, duplicated or reordered.
REQ-029 Bubbles (in_valid low) propagate as cleared valid bits.
REQ-030 When out_ready is low but v3 is low, the pipeline continues to fill.

Reset
REQ-031 rst asserted clears v1..v3 and sets R, G and B to 0 asynchronously; out_valid becomes 0.
REQ-032 Reset mid-stream discards all in-flight pixels.
REQ-033 The first acceptance after reset is possible on the first rising edge after rst deasserts, because in_ready = 1 once v3 = 0.

Structure
REQ-034 Coefficients 359/88/183/454, the offset 128 and the rounding constant reside in a shared package (edge_pkg), reused by the forward YCrCb block.
REQ-035 A single sub-module, clamp8 (signed sum in, 8-bit saturated out), is instantiated 3 times in S3.

Verification
REQ-036 Y=128, Cr=128, Cb=128 with out_ready=1 -> after 3 cycles R=16, G=32, B=16, out_valid=1.
REQ-037 Y=255, Cr=255, Cb=128, ROUND=1 -> R=31 (clamped), G=41 (G8=164), B=31.
REQ-038 Y=0, Cr=0, Cb=0 -> R=0 (clamped), G=34 (G8=136), B=0 (clamped).
REQ-039 Backpressure: out_ready=0 while offering 5 consecutive pixels:
- exactly 3 are accepted and in_ready then stays 0;
- releasing out_ready delivers all 5 in order, with outputs stable while stalled.
REQ-040 Reset mid-stream: assert rst with 3 pixels in flight -> out_valid=0 and RGB=0 immediately; no stale pixel appears after release.
REQ-041 Exhaustive sweep of Y, Cr and Cb in steps of 17 with random in_valid/out_ready:
- outputs match a reference model of REQ-016..REQ-020;
- transfer count matches acceptance count.
